// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath widths, writeback FSM states and the WB register payload.
package pipe_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_REG_NUM_W = 5;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                     valid;
        logic                     is_ld;
        logic                     is_wb;
        logic                     is_halt;
        logic [DEF_REG_NUM_W-1:0] rd_num;
        logic [DEF_DATA_W-1:0]    alu_val;
        logic [DEF_DATA_W-1:0]    dmem_val;
    } wb_entry_t;

endpackage

// File: rtl/wb_pipe_reg.sv
// WB pipeline register: flush beats stall, stall holds, a non-running stage loads bubbles.
module wb_pipe_reg
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      stall,
    input  logic      run,
    input  wb_entry_t entry_in,
    output wb_entry_t entry_out
);

    wb_entry_t entry_d;
    wb_entry_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d = '0;
        end else if (stall) begin
            entry_d = entry_q;
        end else if (!run) begin
            entry_d = '0;
        end else begin
            entry_d = entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_out = entry_q;

endmodule

// File: rtl/writeback.sv
// Writeback stage: drives the register-file write port from the WB register,
// counts retirements and freezes architectural writes after a halt retires.
module writeback
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_NUM_W = DEF_REG_NUM_W,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 resume,
    input  logic                 valid_in,
    input  logic                 is_ld_op_passthrough,
    input  logic                 is_wb_op_passthrough,
    input  logic                 is_halt_op_passthrough,
    input  logic [REG_NUM_W-1:0] rd_num_passthrough,
    input  logic [DATA_W-1:0]    alu_val_passthrough,
    input  logic [DATA_W-1:0]    dmem_val_passthrough,
    output logic                 rf_write_en,
    output logic [REG_NUM_W-1:0] rf_write_num,
    output logic [DATA_W-1:0]    rf_write_val,
    output logic                 halt_req,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired_count
);

    wb_state_e        state_d, state_q;
    logic [CNT_W-1:0] retired_count_d, retired_count_q;
    wb_entry_t        entry_in;
    wb_entry_t        wb_q;
    logic             running;
    logic             retire;

    always_comb begin
        entry_in          = '0;
        entry_in.valid    = valid_in;
        entry_in.is_ld    = is_ld_op_passthrough;
        entry_in.is_wb    = is_wb_op_passthrough;
        entry_in.is_halt  = is_halt_op_passthrough;
        entry_in.rd_num   = rd_num_passthrough;
        entry_in.alu_val  = alu_val_passthrough;
        entry_in.dmem_val = dmem_val_passthrough;
    end

    assign running = (state_q == RUN);

    wb_pipe_reg u_wb_pipe_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .stall     (stall),
        .run       (running),
        .entry_in  (entry_in),
        .entry_out (wb_q)
    );

    // An entry retires in the cycle before it is replaced, so a stalled entry waits.
    assign retire = wb_q.valid & ~stall & running;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (retire && wb_q.is_halt) state_d = HALTED;
            HALTED:  if (resume)                 state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        retired_count_d = retired_count_q;
        if (retire) begin
            retired_count_d = retired_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Halts never write; r0 writes are dropped but the entry still retires.
    assign rf_write_en   = retire & (wb_q.is_ld | wb_q.is_wb) & ~wb_q.is_halt
                         & (wb_q.rd_num != '0);
    assign rf_write_num  = wb_q.rd_num;
    assign rf_write_val  = wb_q.is_ld ? wb_q.dmem_val : wb_q.alu_val;
    assign halt_req      = wb_q.valid & wb_q.is_halt & running;
    assign halted        = (state_q == HALTED);
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: each scenario task drives vectors and checks inline.
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        resume;
    logic        valid_in;
    logic        is_ld;
    logic        is_wb;
    logic        is_halt;
    logic [4:0]  rd_num;
    logic [31:0] alu_val;
    logic [31:0] dmem_val;
    logic        rf_write_en;
    logic [4:0]  rf_write_num;
    logic [31:0] rf_write_val;
    logic        halt_req;
    logic        halted;
    logic [31:0] retired_count;

    int          nvec;
    int          nerr;
    logic [31:0] exp_cnt;

    writeback dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .stall                  (stall),
        .flush                  (flush),
        .resume                 (resume),
        .valid_in               (valid_in),
        .is_ld_op_passthrough   (is_ld),
        .is_wb_op_passthrough   (is_wb),
        .is_halt_op_passthrough (is_halt),
        .rd_num_passthrough     (rd_num),
        .alu_val_passthrough    (alu_val),
        .dmem_val_passthrough   (dmem_val),
        .rf_write_en            (rf_write_en),
        .rf_write_num           (rf_write_num),
        .rf_write_val           (rf_write_val),
        .halt_req               (halt_req),
        .halted                 (halted),
        .retired_count          (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic ld, input logic wb, input logic hlt,
                           input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] dmem);
        valid_in = 1'b1;
        is_ld    = ld;
        is_wb    = wb;
        is_halt  = hlt;
        rd_num   = rd;
        alu_val  = alu;
        dmem_val = dmem;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        is_ld    = 1'b0;
        is_wb    = 1'b0;
        is_halt  = 1'b0;
        rd_num   = '0;
        alu_val  = '0;
        dmem_val = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nvec++;
        if ({rf_write_en, rf_write_num, rf_write_val, halt_req, halted, retired_count} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: en=%0b num=%0d val=%h hreq=%0b halted=%0b cnt=%0d, want all 0",
                     rf_write_en, rf_write_num, rf_write_val, halt_req, halted, retired_count);
        end
        #3 rst_n = 1'b1;
        step();
        nvec++;
        if (rf_write_en !== 1'b0 || retired_count !== 32'd0) begin
            nerr++;
            $display("FAIL reset_release: en=%0b cnt=%0d, want 0 0", rf_write_en, retired_count);
        end
        exp_cnt = 0;
    endtask

    task automatic test_alu();
        present(1'b0, 1'b1, 1'b0, 5'd3, 32'h1234, 32'h0);
        step();
        idle();
        nvec++;
        if (rf_write_en !== 1'b1 || rf_write_num !== 5'd3 || rf_write_val !== 32'h0000_1234) begin
            nerr++;
            $display("FAIL alu_write: en=%0b num=%0d val=%h, want 1 3 00001234",
                     rf_write_en, rf_write_num, rf_write_val);
        end
        step();
        exp_cnt++;
        nvec++;
        if (retired_count !== exp_cnt || rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL alu_count: cnt=%0d en=%0b, want %0d 0", retired_count, rf_write_en, exp_cnt);
        end
    endtask

    task automatic test_load_stall();
        present(1'b1, 1'b0, 1'b0, 5'd7, 32'h5, 32'hDEAD_BEEF);
        step();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++;
            if (rf_write_en !== 1'b0 || retired_count !== exp_cnt) begin
                nerr++;
                $display("FAIL load_stall_%0d: en=%0b cnt=%0d, want 0 %0d",
                         i, rf_write_en, retired_count, exp_cnt);
            end
            step();
        end
        stall = 1'b0;
        #1;
        nvec++;
        if (rf_write_en !== 1'b1 || rf_write_num !== 5'd7 || rf_write_val !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL load_write: en=%0b num=%0d val=%h, want 1 7 deadbeef",
                     rf_write_en, rf_write_num, rf_write_val);
        end
        step();
        exp_cnt++;
        nvec++;
        if (retired_count !== exp_cnt || rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL load_count: cnt=%0d en=%0b, want %0d 0", retired_count, rf_write_en, exp_cnt);
        end
    endtask

    task automatic test_r0();
        present(1'b0, 1'b1, 1'b0, 5'd0, 32'hFF, 32'h0);
        step();
        idle();
        nvec++;
        if (rf_write_en !== 1'b0 || rf_write_val !== 32'hFF) begin
            nerr++;
            $display("FAIL r0_suppress: en=%0b val=%h, want 0 000000ff", rf_write_en, rf_write_val);
        end
        step();
        exp_cnt++;
        nvec++;
        if (retired_count !== exp_cnt) begin
            nerr++;
            $display("FAIL r0_count: cnt=%0d, want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_both_flags();
        present(1'b1, 1'b1, 1'b0, 5'd12, 32'h1111_1111, 32'h2222_2222);
        step();
        idle();
        nvec++;
        if (rf_write_en !== 1'b1 || rf_write_num !== 5'd12 || rf_write_val !== 32'h2222_2222) begin
            nerr++;
            $display("FAIL ld_wins: en=%0b num=%0d val=%h, want 1 12 22222222",
                     rf_write_en, rf_write_num, rf_write_val);
        end
        step();
        exp_cnt++;
    endtask

    task automatic test_flush_stall();
        present(1'b0, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0);
        step();
        idle();
        stall = 1'b1;
        flush = 1'b1;
        #1;
        nvec++;
        if (rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL flush_stall_hold: en=%0b, want 0", rf_write_en);
        end
        step();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        nvec++;
        if (rf_write_en !== 1'b0 || rf_write_num !== 5'd0 || rf_write_val !== 32'd0) begin
            nerr++;
            $display("FAIL flush_bubble: en=%0b num=%0d val=%h, want 0 0 0",
                     rf_write_en, rf_write_num, rf_write_val);
        end
        step();
        nvec++;
        if (retired_count !== exp_cnt) begin
            nerr++;
            $display("FAIL flush_count: cnt=%0d, want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_halt_resume();
        resume = 1'b1;
        step();
        resume = 1'b0;
        nvec++;
        if (halted !== 1'b0) begin
            nerr++;
            $display("FAIL resume_in_run: halted=%0b, want 0", halted);
        end
        present(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0);
        step();
        present(1'b0, 1'b1, 1'b0, 5'd4, 32'h4444, 32'h0);
        nvec++;
        if (halt_req !== 1'b1 || halted !== 1'b0 || rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL halt_in_wb: hreq=%0b halted=%0b en=%0b, want 1 0 0",
                     halt_req, halted, rf_write_en);
        end
        step();
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (halt_req !== 1'b0 || halted !== 1'b1 || rf_write_en !== 1'b0 ||
                retired_count !== exp_cnt) begin
                nerr++;
                $display("FAIL halted_%0d: hreq=%0b halted=%0b en=%0b cnt=%0d, want 0 1 0 %0d",
                         i, halt_req, halted, rf_write_en, retired_count, exp_cnt);
            end
            step();
        end
        resume = 1'b1;
        present(1'b0, 1'b1, 1'b0, 5'd5, 32'h55, 32'h0);
        step();
        resume = 1'b0;
        nvec++;
        if (halted !== 1'b0 || rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL resume: halted=%0b en=%0b, want 0 0", halted, rf_write_en);
        end
        step();
        idle();
        nvec++;
        if (rf_write_en !== 1'b1 || rf_write_num !== 5'd5 || rf_write_val !== 32'h55) begin
            nerr++;
            $display("FAIL post_resume_write: en=%0b num=%0d val=%h, want 1 5 00000055",
                     rf_write_en, rf_write_num, rf_write_val);
        end
        step();
        exp_cnt++;
        nvec++;
        if (retired_count !== exp_cnt) begin
            nerr++;
            $display("FAIL post_resume_count: cnt=%0d, want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_halt_flush();
        present(1'b0, 1'b1, 1'b1, 5'd8, 32'h8, 32'h0);
        step();
        idle();
        flush = 1'b1;
        #1;
        nvec++;
        if (halt_req !== 1'b1 || rf_write_en !== 1'b0) begin
            nerr++;
            $display("FAIL halt_flush_req: hreq=%0b en=%0b, want 1 0", halt_req, rf_write_en);
        end
        step();
        flush = 1'b0;
        exp_cnt++;
        nvec++;
        if (halted !== 1'b1 || retired_count !== exp_cnt) begin
            nerr++;
            $display("FAIL halt_flush_state: halted=%0b cnt=%0d, want 1 %0d",
                     halted, retired_count, exp_cnt);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
    endtask

    task automatic test_async_reset();
        present(1'b1, 1'b0, 1'b0, 5'd6, 32'h0, 32'hCAFE_F00D);
        step();
        idle();
        nvec++;
        if (rf_write_en !== 1'b1 || rf_write_val !== 32'hCAFE_F00D) begin
            nerr++;
            $display("FAIL pre_reset_load: en=%0b val=%h, want 1 cafef00d", rf_write_en, rf_write_val);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({rf_write_en, rf_write_num, rf_write_val, halt_req, halted, retired_count} !== '0) begin
            nerr++;
            $display("FAIL async_reset: en=%0b num=%0d val=%h hreq=%0b halted=%0b cnt=%0d, want all 0",
                     rf_write_en, rf_write_num, rf_write_val, halt_req, halted, retired_count);
        end
        step();
        #2 rst_n = 1'b1;
        step();
        nvec++;
        if (rf_write_en !== 1'b0 || retired_count !== 32'd0) begin
            nerr++;
            $display("FAIL after_reset: en=%0b cnt=%0d, want 0 0", rf_write_en, retired_count);
        end
    endtask

    initial begin
        nvec    = 0;
        nerr    = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        resume  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_load_stall();
        test_r0();
        test_both_flags();
        test_flush_stall();
        test_halt_resume();
        test_halt_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
